// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared encodings for the instruction-decode stage.
//   - opcodes of the four recognised instruction formats
//   - branch funct3 codes
//   - alu_op encodings driven onto the ID/EX register
//   - hazard FSM state encoding
//   - control bundle type and immediate extraction helper
package id_stage_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // 32-bit sign-extended immediate; the stage resizes it to XLEN.
  function automatic logic signed [31:0] imm32(input logic [31:0] instr);
    logic signed [31:0] res;
    case (instr[6:0])
      OPC_LOAD:   res = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:  res = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH: res = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
      default:    res = '0;
    endcase
    return res;
  endfunction

  // Control bundle for a recognised opcode; anything else yields all zero.
  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
    ctrl_t c;
    c = CTRL_NOP;
    case (opcode)
      OPC_R: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_R;
      end
      OPC_LOAD: begin
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALU_OP_ADD;
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        c.alu_op = ALU_OP_BR;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: NREGS x XLEN register file, two read ports, one write port.
//   clock, reset (async, active-low, clears all registers)
//   wr_en/wr_addr/wr_data   : write on rising edge when wr_en
//   rd_addr_a/b -> rd_data_a/b : combinational reads; register 0 always
//                              reads 0; a write in the same cycle to the
//                              read address is bypassed to the read data.
module id_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [RAW-1:0]  wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [RAW-1:0]  rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  input  logic [RAW-1:0]  rd_addr_b,
  output logic [XLEN-1:0] rd_data_b
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_q[rd_addr_a];
    end
  end

  always_comb begin
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_q[rd_addr_b];
    end
  end

endmodule

// File: rtl/id_stage_param.sv
// id_stage_param: instruction-decode stage of a 5-stage pipeline.
//   clock, reset (async, active-low)
//   in_valid/instruction/pc        : IF/ID register contents
//   wb_en/wb_addr/wb_data          : register-file write port
//   ex_* / mem_*                   : destination info of instructions in EX/MEM
//   pc_enable/if_id_enable         : upstream hold (0 = hold) during stalls
//   branch_taken/if_flush/branch_target : combinational ID-resolved redirect
//   out_valid ... illegal          : registered ID/EX outputs
// Build option: define ID_STAGE_BNE_EN to decode SB funct3=001 as BNE;
// otherwise only BEQ is a recognised branch and other funct3 are illegal.
//
// Hazard FSM:
//   state    | meaning
//   ST_RUN   | no hazard last cycle; instruction issued or bubble loaded
//   ST_STALL | holding IF/ID for a load-use or branch-operand hazard
module id_stage_param
  import id_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RAW   = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [RAW-1:0]  ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [RAW-1:0]  mem_rd,
  input  logic            mem_reg_write,
  input  logic            mem_mem_read,
  input  logic [XLEN-1:0] mem_alu_result,
  output logic            pc_enable,
  output logic            if_id_enable,
  output logic            branch_taken,
  output logic            if_flush,
  output logic [XLEN-1:0] branch_target,
  output logic            out_valid,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic [RAW-1:0]  rs1,
  output logic [RAW-1:0]  rs2,
  output logic [RAW-1:0]  rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] reg_a,
  output logic [XLEN-1:0] reg_b,
  output logic [6:0]      funct7,
  output logic [2:0]      funct3,
  output logic            illegal
);

  typedef struct packed {
    logic            valid;
    logic            illegal;
    ctrl_t           ctrl;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [6:0]      f7;
    logic [2:0]      f3;
  } idex_t;

  // Field extraction
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [RAW-1:0]  rs1_idx;
  logic [RAW-1:0]  rs2_idx;
  logic [RAW-1:0]  rd_idx;
  logic signed [31:0] imm_s;
  logic [XLEN-1:0] imm_ext;

  assign opcode  = instruction[6:0];
  assign f3      = instruction[14:12];
  assign f7      = instruction[31:25];
  assign rs1_idx = RAW'(instruction[19:15]);
  assign rs2_idx = RAW'(instruction[24:20]);
  assign rd_idx  = RAW'(instruction[11:7]);
  assign imm_s   = imm32(instruction);
  assign imm_ext = XLEN'(imm_s);

  // Format classification
  logic is_r, is_load, is_store, is_sb;
  logic br_beq, br_bne, is_branch, legal, uses_rs2;

  assign is_r     = (opcode == OPC_R);
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_sb    = (opcode == OPC_BRANCH);
  assign br_beq   = is_sb && (f3 == F3_BEQ);
`ifdef ID_STAGE_BNE_EN
  assign br_bne   = is_sb && (f3 == F3_BNE);
`else
  assign br_bne   = 1'b0;
`endif
  assign is_branch = br_beq || br_bne;
  assign legal     = is_r || is_load || is_store || is_branch;
  assign uses_rs2  = is_r || is_store || is_branch;

  // Register file
  logic [XLEN-1:0] rf_a, rf_b;

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (rs1_idx),
    .rd_data_a (rf_a),
    .rd_addr_b (rs2_idx),
    .rd_data_b (rf_b)
  );

  // Hazard detection
  logic load_use, br_stall, stall;
  logic ex_hit, mem_ld_hit;

  assign load_use = in_valid && ex_mem_read && (ex_rd != '0) &&
                    ((legal && (ex_rd == rs1_idx)) ||
                     (uses_rs2 && (ex_rd == rs2_idx)));

  // A branch resolves in ID, so it must also wait for an ALU result still in
  // EX and for load data still in MEM; only MEM ALU results can be forwarded.
  assign ex_hit     = ex_reg_write && (ex_rd != '0) &&
                      ((ex_rd == rs1_idx) || (ex_rd == rs2_idx));
  assign mem_ld_hit = mem_mem_read && (mem_rd != '0) &&
                      ((mem_rd == rs1_idx) || (mem_rd == rs2_idx));
  assign br_stall   = in_valid && is_branch && (ex_hit || mem_ld_hit);

  assign stall = load_use || br_stall;

  // Branch resolution
  logic            fwd_ok;
  logic [XLEN-1:0] op_a, op_b;
  logic            ops_eq;

  assign fwd_ok = mem_reg_write && !mem_mem_read && (mem_rd != '0);
  assign op_a   = (fwd_ok && (mem_rd == rs1_idx)) ? mem_alu_result : rf_a;
  assign op_b   = (fwd_ok && (mem_rd == rs2_idx)) ? mem_alu_result : rf_b;
  assign ops_eq = (op_a == op_b);

  assign branch_taken  = in_valid && !stall &&
                         ((br_beq && ops_eq) || (br_bne && !ops_eq));
  assign if_flush      = branch_taken;
  assign branch_target = pc + imm_ext;

  assign pc_enable    = !stall;
  assign if_id_enable = !stall;

  // Hazard FSM
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (stall)  state_d = ST_STALL;
      ST_STALL: if (!stall) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ID/EX register; stalls, empty slots and illegal words load zeros
  idex_t idex_q, idex_d;

  always_comb begin
    idex_d = '0;
    if (in_valid && !stall) begin
      if (legal) begin
        idex_d.valid = 1'b1;
        idex_d.ctrl  = decode_ctrl(opcode);
        idex_d.rs1   = rs1_idx;
        idex_d.rs2   = rs2_idx;
        idex_d.rd    = rd_idx;
        idex_d.imm   = imm_ext;
        idex_d.a     = rf_a;
        idex_d.b     = rf_b;
        idex_d.f7    = f7;
        idex_d.f3    = f3;
      end else begin
        idex_d.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign out_valid  = idex_q.valid;
  assign illegal    = idex_q.illegal;
  assign mem_to_reg = idex_q.ctrl.mem_to_reg;
  assign reg_write  = idex_q.ctrl.reg_write;
  assign mem_read   = idex_q.ctrl.mem_read;
  assign mem_write  = idex_q.ctrl.mem_write;
  assign branch     = idex_q.ctrl.branch;
  assign alu_src    = idex_q.ctrl.alu_src;
  assign alu_op     = idex_q.ctrl.alu_op;
  assign rs1        = idex_q.rs1;
  assign rs2        = idex_q.rs2;
  assign rd         = idex_q.rd;
  assign imm        = idex_q.imm;
  assign reg_a      = idex_q.a;
  assign reg_b      = idex_q.b;
  assign funct7     = idex_q.f7;
  assign funct3     = idex_q.f3;

endmodule

// File: tb/tb_id_stage_param.sv
// Scoreboard bench for id_stage_param: the driver pushes the expected
// response for each applied cycle; the monitor pops it, checks the
// combinational redirect/hold outputs mid-cycle and the ID/EX outputs
// just after the following rising edge.
module tb_id_stage_param;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RAW   = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            wb_en;
  logic [RAW-1:0]  wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [RAW-1:0]  ex_rd;
  logic            ex_reg_write, ex_mem_read;
  logic [RAW-1:0]  mem_rd;
  logic            mem_reg_write, mem_mem_read;
  logic [XLEN-1:0] mem_alu_result;
  logic            pc_enable, if_id_enable, branch_taken, if_flush;
  logic [XLEN-1:0] branch_target;
  logic            out_valid, mem_to_reg, reg_write, mem_read, mem_write;
  logic            branch, alu_src, illegal;
  logic [1:0]      alu_op;
  logic [RAW-1:0]  rs1, rs2, rd;
  logic [XLEN-1:0] imm, reg_a, reg_b;
  logic [6:0]      funct7;
  logic [2:0]      funct3;

  always #5 clock = ~clock;

  id_stage_param #(.XLEN(XLEN), .NREGS(NREGS), .RAW(RAW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .instruction(instruction), .pc(pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_alu_result(mem_alu_result),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable),
    .branch_taken(branch_taken), .if_flush(if_flush),
    .branch_target(branch_target),
    .out_valid(out_valid), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .alu_src(alu_src), .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .reg_a(reg_a), .reg_b(reg_b), .funct7(funct7),
    .funct3(funct3), .illegal(illegal)
  );

  // ctrl byte order: {out_valid, illegal, mem_to_reg, reg_write,
  //                   mem_read, mem_write, branch, alu_src}
  localparam logic [7:0] C_NOP = 8'h00;
  localparam logic [7:0] C_R   = 8'h90;
  localparam logic [7:0] C_LD  = 8'hB9;
  localparam logic [7:0] C_S   = 8'h85;
  localparam logic [7:0] C_B   = 8'h82;
  localparam logic [7:0] C_ILL = 8'h40;

  typedef struct {
    string       name;
    bit          chk_comb;
    bit          pc_en;
    bit          taken;
    bit          chk_tgt;
    logic [31:0] tgt;
    bit          chk_reg;
    logic [7:0]  ctrl;
    logic [1:0]  op;
    bit          chk_a;
    logic [31:0] a;
    bit          chk_b;
    logic [31:0] b;
    bit          chk_imm;
    logic [31:0] immv;
  } item_t;

  item_t sb_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic cmp(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", n, act, exp);
    end
  endtask

  function automatic item_t mk(input string n, input bit pc_en,
                               input bit taken, input logic [7:0] ctrl,
                               input logic [1:0] op);
    item_t it;
    it.name = n;   it.chk_comb = 1'b1; it.pc_en = pc_en; it.taken = taken;
    it.chk_tgt = 1'b0; it.tgt = '0;
    it.chk_reg = 1'b1; it.ctrl = ctrl; it.op = op;
    it.chk_a = 1'b0; it.a = '0; it.chk_b = 1'b0; it.b = '0;
    it.chk_imm = 1'b0; it.immv = '0;
    return it;
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rdi,
                                        input logic [4:0] r1,
                                        input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_ld(input logic [4:0] rdi,
                                         input logic [4:0] r1,
                                         input logic [11:0] im);
    return {im, r1, 3'b010, rdi, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] r2,
                                        input logic [4:0] r1,
                                        input logic [11:0] im);
    return {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3,
                                        input logic [4:0] r1,
                                        input logic [4:0] r2,
                                        input logic [12:0] im);
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  task automatic clr();
    in_valid = 1'b0; instruction = '0; pc = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    mem_alu_result = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] p);
    in_valid = 1'b1; instruction = ins; pc = p;
  endtask

  task automatic step(input item_t it);
    sb_q.push_back(it);
    @(posedge clock);
    #2;
  endtask

  // Monitor
  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clock);
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        if (it.chk_comb) begin
          cmp({it.name, ".pc_enable"},    32'(pc_enable),    32'(it.pc_en));
          cmp({it.name, ".if_id_enable"}, 32'(if_id_enable), 32'(it.pc_en));
          cmp({it.name, ".branch_taken"}, 32'(branch_taken), 32'(it.taken));
          cmp({it.name, ".if_flush"},     32'(if_flush),     32'(it.taken));
          if (it.chk_tgt)
            cmp({it.name, ".branch_target"}, branch_target, it.tgt);
        end
        @(posedge clock);
        #1;
        if (it.chk_reg) begin
          cmp({it.name, ".ctrl"},
              32'({out_valid, illegal, mem_to_reg, reg_write,
                   mem_read, mem_write, branch, alu_src}), 32'(it.ctrl));
          cmp({it.name, ".alu_op"}, 32'(alu_op), 32'(it.op));
          if (it.chk_a)   cmp({it.name, ".reg_a"}, reg_a, it.a);
          if (it.chk_b)   cmp({it.name, ".reg_b"}, reg_b, it.b);
          if (it.chk_imm) cmp({it.name, ".imm"},   imm,   it.immv);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin : driver
    item_t it;
    clr();
    reset = 1'b0;
    @(posedge clock);
    #2;

    // Held in reset with a valid instruction and a write pending
    issue(enc_r(5'd3, 5'd5, 5'd0), 32'h0);
    wb(5'd1, 32'hDEAD);
    it = mk("rst_hold", 1, 0, C_NOP, 2'b00);
    it.chk_comb = 1'b0; it.chk_a = 1; it.a = 0; it.chk_imm = 1; it.immv = 0;
    step(it);
    reset = 1'b1;
    clr();

    // add x3,x5,x0 with same-cycle write of x5
    wb(5'd5, 32'h1234);
    issue(enc_r(5'd3, 5'd5, 5'd0), 32'h0);
    it = mk("add_bypass", 1, 0, C_R, 2'b10);
    it.chk_a = 1; it.a = 32'h1234; it.chk_b = 1; it.b = 0;
    step(it); clr();

    wb(5'd1, 32'd7);
    step(mk("wb_x1", 1, 0, C_NOP, 2'b00)); clr();

    // beq x1,x2,+16 @0x100, x2=7 via bypass
    wb(5'd2, 32'd7);
    issue(enc_b(3'b000, 5'd1, 5'd2, 13'd16), 32'h100);
    it = mk("beq_taken", 1, 1, C_B, 2'b01);
    it.chk_tgt = 1; it.tgt = 32'h110; it.chk_a = 1; it.a = 7;
    it.chk_b = 1; it.b = 7; it.chk_imm = 1; it.immv = 32'h10;
    step(it); clr();

    wb(5'd2, 32'd8);
    issue(enc_b(3'b000, 5'd1, 5'd2, 13'd16), 32'h100);
    it = mk("beq_not", 1, 0, C_B, 2'b01);
    it.chk_tgt = 1; it.tgt = 32'h110; it.chk_b = 1; it.b = 8;
    step(it); clr();

    wb(5'd2, 32'd9);
    step(mk("wb_x2", 1, 0, C_NOP, 2'b00)); clr();

    // x1 forwarded from MEM (9) equals x2 (9); target wraps
    mem_rd = 5'd1; mem_alu_result = 32'd9; mem_reg_write = 1'b1;
    issue(enc_b(3'b000, 5'd1, 5'd2, 13'd32), 32'hFFFF_FFF0);
    it = mk("beq_fwd_wrap", 1, 1, C_B, 2'b01);
    it.chk_tgt = 1; it.tgt = 32'h10; it.chk_imm = 1; it.immv = 32'h20;
    step(it);

    // Same, but MEM holds a load: must stall
    mem_mem_read = 1'b1;
    step(mk("br_stall_mem", 0, 0, C_NOP, 2'b00)); clr();

    issue(enc_b(3'b000, 5'd1, 5'd2, 13'd32), 32'hFFFF_FFF0);
    it = mk("beq_nofwd", 1, 0, C_B, 2'b01);
    it.chk_a = 1; it.a = 7; it.chk_b = 1; it.b = 9;
    step(it); clr();

    // lw x2 in EX, add x4,x2,x1 in ID: one stall, then issue
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd2;
    issue(enc_r(5'd4, 5'd2, 5'd1), 32'h40);
    step(mk("lu_stall", 0, 0, C_NOP, 2'b00)); clr();

    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd2;
    mem_alu_result = 32'h55;
    issue(enc_r(5'd4, 5'd2, 5'd1), 32'h40);
    it = mk("lu_issue", 1, 0, C_R, 2'b10);
    it.chk_a = 1; it.a = 9; it.chk_b = 1; it.b = 7;
    step(it); clr();

    // lw x6,-4(x1): rs2 field (28) matches EX load rd, but loads ignore rs2
    ex_mem_read = 1'b1; ex_rd = 5'd28;
    issue(enc_ld(5'd6, 5'd1, 12'hFFC), 32'h44);
    it = mk("lw_no_rs2", 1, 0, C_LD, 2'b00);
    it.chk_a = 1; it.a = 7; it.chk_imm = 1; it.immv = 32'hFFFF_FFFC;
    step(it); clr();

    // sw x1,8(x0) with EX load to x0: no stall
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    issue(enc_s(5'd1, 5'd0, 12'd8), 32'h48);
    it = mk("sw_x0", 1, 0, C_S, 2'b00);
    it.chk_a = 1; it.a = 0; it.chk_b = 1; it.b = 7;
    it.chk_imm = 1; it.immv = 32'h8;
    step(it); clr();

    // lw x1 then dependent beq: two stall cycles
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd1;
    issue(enc_b(3'b000, 5'd1, 5'd2, 13'd16), 32'h100);
    step(mk("lbr_stall1", 0, 0, C_NOP, 2'b00)); clr();

    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd1;
    issue(enc_b(3'b000, 5'd1, 5'd2, 13'd16), 32'h100);
    step(mk("lbr_stall2", 0, 0, C_NOP, 2'b00)); clr();

    issue(enc_b(3'b000, 5'd1, 5'd2, 13'd16), 32'h100);
    it = mk("lbr_issue", 1, 0, C_B, 2'b01);
    it.chk_a = 1; it.a = 7; it.chk_b = 1; it.b = 9;
    step(it); clr();

    issue(32'h0000_007F, 32'h50);
    step(mk("illegal_opc", 1, 0, C_ILL, 2'b00)); clr();

    instruction = enc_r(5'd4, 5'd2, 5'd1);
    step(mk("no_valid", 1, 0, C_NOP, 2'b00)); clr();

    // bne x1,x2,+8 with x1=3, x2=4
    wb(5'd1, 32'd3);
    step(mk("wb_x1_3", 1, 0, C_NOP, 2'b00)); clr();
    wb(5'd2, 32'd4);
    issue(enc_b(3'b001, 5'd1, 5'd2, 13'd8), 32'h200);
`ifdef ID_STAGE_BNE_EN
    it = mk("bne", 1, 1, C_B, 2'b01);
    it.chk_tgt = 1; it.tgt = 32'h208;
`else
    it = mk("bne_illegal", 1, 0, C_ILL, 2'b00);
`endif
    step(it); clr();

    // Reset in the middle of a stall
    ex_mem_read = 1'b1; ex_rd = 5'd1;
    issue(enc_r(5'd4, 5'd1, 5'd0), 32'h60);
    step(mk("stall_pre_rst", 0, 0, C_NOP, 2'b00));
    reset = 1'b0;
    it = mk("rst_mid", 0, 0, C_NOP, 2'b00);
    it.chk_comb = 1'b0; it.chk_a = 1; it.a = 0; it.chk_imm = 1; it.immv = 0;
    step(it);
    reset = 1'b1; clr();
    step(mk("rst_rel", 1, 0, C_NOP, 2'b00));

    issue(enc_r(5'd5, 5'd1, 5'd0), 32'h64);
    it = mk("x1_after_rst", 1, 0, C_R, 2'b10);
    it.chk_a = 1; it.a = 0;
    step(it); clr();

    step(mk("tail", 1, 0, C_NOP, 2'b00));

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clock);
    if (sb_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end
    @(posedge clock);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_param.md
ID_STAGE_PARAM -- requirements
Module: id_stage_param

Interface
REQ-001 Parameters SHALL be: XLEN, 32, datapath/PC width; NREGS, 32, register count (power of two, >=2); RAW, $clog2(NREGS), register address width.
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  IF/ID holds a valid instruction; instruction  in  32  encoded word; pc  in  XLEN  its PC.
REQ-005 wb_en  in  1, wb_addr  in  RAW, wb_data  in  XLEN: register-file write port.
REQ-006 ex_rd  in  RAW, ex_reg_write  in  1, ex_mem_read  in  1: instruction currently in EX.
REQ-007 mem_rd  in  RAW, mem_reg_write  in  1, mem_mem_read  in  1, mem_alu_result  in  XLEN: instruction currently in MEM.
REQ-008 pc_enable  out  1, if_id_enable  out  1: upstream hold controls (0 = hold).
REQ-009 branch_taken  out  1, if_flush  out  1, branch_target  out  XLEN: ID-resolved redirect.
REQ-010 Registered ID/EX outputs: out_valid 1, mem_to_reg 1, reg_write 1, mem_read 1, mem_write 1, branch 1, alu_src 1, alu_op 2, rs1/rs2/rd RAW, imm XLEN, reg_a/reg_b XLEN, funct7 7, funct3 3, illegal 1.

Function
REQ-011 Decode SHALL recognise R (0110011), load (0000011), S (0100011), SB (1100011); any other opcode with in_valid SHALL register illegal=1, out_valid=0, all controls 0.
REQ-012 Control: R -> reg_write, alu_op=10; load -> mem_read, mem_to_reg, reg_write, alu_src, alu_op=00; S -> mem_write, alu_src, alu_op=00; SB -> branch, alu_op=01.
REQ-013 Immediate SHALL be sign-extended to XLEN: I from [31:20], S from {[31:25],[11:7]}, SB from {[31],[7],[30:25],[11:8],1'b0}; R yields 0.
REQ-014 Register file: NREGS x XLEN, register 0 reads 0 and ignores writes; write on clock edge when wb_en; a same-cycle write to a read address SHALL be bypassed to the read data.
REQ-015 Load-use stall: in_valid && ex_mem_read && ex_rd!=0 && ex_rd matches a used source (rs1 for all recognised types, rs2 for R/S/SB).
REQ-016 Branch stall: SB && ((ex_reg_write && ex_rd!=0 && ex_rd matches rs1/rs2) || (mem_mem_read && mem_rd!=0 && mem_rd matches rs1/rs2)).
REQ-017 Branch operands SHALL forward mem_alu_result when mem_reg_write && !mem_mem_read && mem_rd!=0 && mem_rd matches, else register-file read.
REQ-018 FSM states RUN, STALL: RUN->STALL when a stall condition holds; STALL->RUN when none holds; STALL persists while conditions persist (load then dependent branch = 2 cycles).
REQ-019 During any stall cycle: pc_enable=0, if_id_enable=0, branch_taken=0, ID/EX loads a bubble (out_valid=0, all controls 0, data fields don't-care).
REQ-020 Non-stall cycle: pc_enable=1, if_id_enable=1, ID/EX loads decoded fields with out_valid=in_valid; in_valid=0 loads a bubble.
REQ-021 branch_taken = if_flush = valid, non-stalled SB with BEQ (funct3=000) and equal operands; combinational, same cycle.
REQ-022 branch_target = pc + imm modulo 2^XLEN (wrap-around, no flag).
REQ-023 Latency: decoded instruction appears on ID/EX outputs exactly one clock after acceptance.

Reset
REQ-024 While reset=0 all ID/EX outputs, illegal and all registers SHALL be 0, FSM SHALL be RUN; release takes effect on the next edge.
REQ-025 Reset asserted mid-stall SHALL abandon the stall; no instruction is replayed by this block.

Configuration
REQ-026 With ID_STAGE_BNE_EN defined, SB funct3=001 SHALL be BNE (taken when operands differ); without it, SB funct3 other than 000 SHALL be illegal per REQ-011.

Structure
REQ-027 Opcodes, alu_op encodings and FSM state encodings SHALL live in shared package id_stage_pkg.
REQ-028 The register file SHALL be sub-module id_regfile (parameters XLEN, NREGS); decode, hazard and ID/EX register stay in id_stage_param.

Verification
REQ-029 Reset: reset=0 mid-run -> all outputs 0, FSM RUN, x1 reads 0 after release.
REQ-030 wb_en=1 wb_addr=5 wb_data=0x1234 while decoding add x3,x5,x0 -> next cycle reg_a=0x1234, reg_write=1, alu_op=10.
REQ-031 EX lw x2 (ex_mem_read=1, ex_rd=2), ID add x4,x2,x1 -> one cycle pc_enable=0, if_id_enable=0, out_valid=0; add issues next cycle.
REQ-032 x1=x2=7, beq x1,x2,+16 at pc=0x100 -> branch_taken=if_flush=1, branch_target=0x110; x2=8 -> branch_taken=0.
REQ-033 mem_rd=1, mem_alu_result=9, mem_reg_write=1, x2=9, beq x1,x2 -> taken with no stall; pc=0xFFFFFFF0 with +32 -> target 0x00000010.
REQ-034 Opcode 0x7F -> illegal=1, out_valid=0; bne with ID_STAGE_BNE_EN undefined -> illegal=1, defined and operands 3/4 -> taken.
